exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle sequencer for the register-file / ALU / data-memory datapath. It accepts one 32-bit instruction per valid/ready handshake and drives the datapath control signals over 2–4 cycles: rf addresses and write enable, dm address, read and write enables, and alu_op. It replaces per-opcode ad-hoc logic with a single Moore FSM. It sits between the instruction source and the datapath, and is the only driver of those control signals.

## Interface
- `SIZE`, 32, instruction width.
- `SCRATCH_ADDR`, 5'd31, data-memory word used as the ALU-result staging slot for ADD/SUB.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `instr`  in  SIZE  instruction. Field layout:
  - [1:0] op: 00 LW, 01 SW, 10 ADD, 11 SUB.
  - [6:2] rd, [11:7] rs1, [16:12] rs2, [21:17] maddr.
  - [31:22] ignored.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept; high only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the final state of an instruction.
- `err`  out  1  one-cycle pulse on a rejected instruction (see Configuration).
- `rf_write_enable`  out  1; `rf_write_addr`  out  5; `rf_addr_a`  out  5; `rf_addr_b`  out  5.
- `dm_write_enable`  out  1; `dm_write_addr`  out  5 (dm address for both read and write); `dm_read`  out  1.
- `alu_op`  out  1  0 = add, 1 = sub.

## Operation
- States: IDLE, READ, MEM_WR, MEM_RD, WB.
- Outputs are decoded from the state register and the latched instruction fields. In IDLE all datapath controls are 0.
- Accept: in IDLE, when `instr_valid`=1 on a rising edge, `instr` is latched and the FSM leaves IDLE. The source holds `instr` until accepted. `instr_valid` is ignored while busy.
- LW (op 00): IDLE→MEM_RD→WB→IDLE.
  - MEM_RD: dm_read=1, dm_write_addr=maddr.
  - WB: rf_write_enable=1, rf_write_addr=rd, done=1.
- SW (op 01): IDLE→READ→MEM_WR→IDLE.
  - READ and MEM_WR: rf_addr_a=rs1, rf_addr_b=0 (zero register), alu_op=0.
  - MEM_WR: dm_write_enable=1, dm_write_addr=maddr, done=1.
- ADD/SUB (op 10/11): IDLE→READ→MEM_WR→MEM_RD→WB→IDLE.
  - READ and MEM_WR: rf_addr_a=rs1, rf_addr_b=rs2, alu_op=op[0].
  - MEM_WR: dm_write_enable=1, dm_write_addr=SCRATCH_ADDR.
  - MEM_RD: dm_read=1, dm_write_addr=SCRATCH_ADDR.
  - WB: rf_write_enable=1, rf_write_addr=rd, done=1.
- ADD/SUB overwrite DM[SCRATCH_ADDR]. rd=0 is written as issued.
- Latched fields are stable from the accept edge until return to IDLE. Changes on `instr` during that window have no effect.
- Every unused control output is 0 in every state. dm_read and dm_write_enable are never both 1.

## Timing
- Reset: state=IDLE. instr_ready=1. All other outputs 0, asynchronously, without waiting for a clock edge.
- Reset mid-instruction: the instruction is dropped, no done, no further dm/rf enables. The next accept is possible on the first edge after `rst` deasserts.
- Latency from the accept edge to the done cycle: LW 2 cycles, SW 2, ADD/SUB 4.
- Throughput: one IDLE cycle minimum between instructions. Periods are 3 cycles for LW/SW and 5 for ADD/SUB.
- The register file must have a combinational read port, so the ALU result is valid during READ/MEM_WR.
- Data memory read data is valid in the cycle after dm_read, i.e. in WB.

## Configuration
- `EXEC_SEQ_SCRATCH_GUARD_EN`:
  - Defined: an LW or SW with maddr == SCRATCH_ADDR is rejected at accept. The FSM stays in IDLE, err=1 for one cycle, no datapath enables, no done.
  - Undefined: no check, such instructions execute normally, and err is tied 0.

## Test plan
- Reset with rst=1 mid-ADD (in MEM_RD) → all controls 0 immediately, no done. After release, instr_ready=1.
- LW rd=3 maddr=5 → cycle+1: dm_read=1, dm_write_addr=5. Cycle+2: rf_write_enable=1, rf_write_addr=3, done=1.
- SW rs1=7 maddr=9, with R7=0x1234 → cycle+2: dm_write_enable=1, dm_write_addr=9, rf_addr_a=7, rf_addr_b=0, alu_op=0. DM[9]=0x1234 afterwards.
- SUB rd=4 rs1=1 rs2=2, with R1=10 and R2=3 → MEM_WR writes DM[31]=7 with alu_op=1. WB writes R4=7. done at cycle+4.
- Back-to-back: instr_valid held high with LW then ADD → the second instruction is accepted only at the edge after LW's WB. instr_ready=0 throughout busy.
- With the macro defined: SW maddr=31 → err=1 for one cycle, no dm_write_enable, busy stays 0. Without the macro: a normal 2-cycle SW to address 31.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle Moore sequencer driving register-file / ALU / data-memory controls.
// Optional EXEC_SEQ_SCRATCH_GUARD_EN rejects LW/SW that target the scratch word.
module exec_sequencer #(
   parameter int         SIZE         = 32,
   parameter logic [4:0] SCRATCH_ADDR = 5'd31
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            rf_write_enable,
   output logic [4:0]      rf_write_addr,
   output logic [4:0]      rf_addr_a,
   output logic [4:0]      rf_addr_b,
   output logic            dm_write_enable,
   output logic [4:0]      dm_write_addr,
   output logic            dm_read,
   output logic            alu_op
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_READ   = 3'd1;
   localparam logic [2:0] S_MEM_WR = 3'd2;
   localparam logic [2:0] S_MEM_RD = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [1:0] OP_LW = 2'b00;
   localparam logic [1:0] OP_SW = 2'b01;

   logic [2:0] state_reg, state_next;
   logic [1:0] op_reg;
   logic [4:0] rd_reg, rs1_reg, rs2_reg, maddr_reg;
   logic       reject;
   logic       accept;
   logic       is_sw, is_lw;
   logic       unused_instr_bits;

   assign unused_instr_bits = ^instr[SIZE-1:22];

`ifdef EXEC_SEQ_SCRATCH_GUARD_EN
   logic err_reg;

   // Memory ops (op[1]==0) must not touch the ALU staging word.
   assign reject = (instr[1] == 1'b0) && (instr[21:17] == SCRATCH_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= (state_reg == S_IDLE) && instr_valid && reject;
      end
   end

   assign err = err_reg;
`else
   assign reject = 1'b0;
   assign err    = 1'b0;
`endif

   assign accept = (state_reg == S_IDLE) && instr_valid && !reject;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (accept) state_next = (instr[1:0] == OP_LW) ? S_MEM_RD : S_READ;
         S_READ:   state_next = S_MEM_WR;
         S_MEM_WR: state_next = (op_reg == OP_SW) ? S_IDLE : S_MEM_RD;
         S_MEM_RD: state_next = S_WB;
         S_WB:     state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         op_reg    <= 2'b00;
         rd_reg    <= 5'd0;
         rs1_reg   <= 5'd0;
         rs2_reg   <= 5'd0;
         maddr_reg <= 5'd0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg    <= instr[1:0];
            rd_reg    <= instr[6:2];
            rs1_reg   <= instr[11:7];
            rs2_reg   <= instr[16:12];
            maddr_reg <= instr[21:17];
         end
      end
   end

   assign is_sw       = (op_reg == OP_SW);
   assign is_lw       = (op_reg == OP_LW);
   assign instr_ready = (state_reg == S_IDLE);
   assign busy        = (state_reg != S_IDLE);

   // Controls depend only on state and latched fields, so reset clears them at once.
   always_comb begin
      done            = 1'b0;
      rf_write_enable = 1'b0;
      rf_write_addr   = 5'd0;
      rf_addr_a       = 5'd0;
      rf_addr_b       = 5'd0;
      dm_write_enable = 1'b0;
      dm_write_addr   = 5'd0;
      dm_read         = 1'b0;
      alu_op          = 1'b0;
      case (state_reg)
         S_READ: begin
            rf_addr_a = rs1_reg;
            rf_addr_b = is_sw ? 5'd0 : rs2_reg;
            alu_op    = is_sw ? 1'b0 : op_reg[0];
         end
         S_MEM_WR: begin
            rf_addr_a       = rs1_reg;
            rf_addr_b       = is_sw ? 5'd0 : rs2_reg;
            alu_op          = is_sw ? 1'b0 : op_reg[0];
            dm_write_enable = 1'b1;
            dm_write_addr   = is_sw ? maddr_reg : SCRATCH_ADDR;
            done            = is_sw;
         end
         S_MEM_RD: begin
            dm_read       = 1'b1;
            dm_write_addr = is_lw ? maddr_reg : SCRATCH_ADDR;
         end
         S_WB: begin
            rf_write_enable = 1'b1;
            rf_write_addr   = rd_reg;
            done            = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized bench for exec_sequencer: per-cycle control expectations from the
// instruction rules, plus a small datapath whose contents are checked against arithmetic.
module tb_exec_sequencer;

`ifdef EXEC_SEQ_SCRATCH_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready, busy, done, err;
   logic        rf_write_enable, dm_write_enable, dm_read, alu_op;
   logic [4:0]  rf_write_addr, rf_addr_a, rf_addr_b, dm_write_addr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] gr [32];
   logic [31:0] gd [32];
   logic [31:0] rf [32];
   logic [31:0] dm [32];
   logic [31:0] dm_rdata;
   logic        preload;
   logic [27:0] exp_q [$];

   always #5 clk = ~clk;

   exec_sequencer #(.SIZE(32), .SCRATCH_ADDR(5'd31)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .busy(busy), .done(done), .err(err),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .dm_write_enable(dm_write_enable), .dm_write_addr(dm_write_addr),
      .dm_read(dm_read), .alu_op(alu_op)
   );

   // Datapath: combinational rf read with zero register, registered dm read.
   logic [31:0] op_a, op_b, alu_y;
   assign op_a  = (rf_addr_a == 5'd0) ? 32'd0 : rf[rf_addr_a];
   assign op_b  = (rf_addr_b == 5'd0) ? 32'd0 : rf[rf_addr_b];
   assign alu_y = alu_op ? op_a - op_b : op_a + op_b;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= gr[i];
            dm[i] <= gd[i];
         end
      end else begin
         if (dm_write_enable) dm[dm_write_addr] <= alu_y;
         if (dm_read) dm_rdata <= dm[dm_write_addr];
         if (rf_write_enable && rf_write_addr != 5'd0) rf[rf_write_addr] <= dm_rdata;
      end
   end

   logic [27:0] obs;
   assign obs = {instr_ready, busy, done, err, rf_write_enable, rf_write_addr,
                 rf_addr_a, rf_addr_b, dm_write_enable, dm_write_addr, dm_read, alu_op};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   function automatic logic [27:0] mk(input bit b, input bit dn, input bit er, input bit rwe,
                                      input logic [4:0] rwa, input logic [4:0] ra,
                                      input logic [4:0] rb, input bit dwe,
                                      input logic [4:0] da, input bit dr, input bit al);
      return {~b, b, dn, er, rwe, rwa, ra, rb, dwe, da, dr, al};
   endfunction

   function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] maddr);
      logic [31:0] hi;
      hi = $urandom;
      return {hi[9:0], maddr, rs2, rs1, rd, op};
   endfunction

   // Expected control trace after the accept edge, and golden state update.
   task automatic plan(input logic [31:0] ins);
      logic [1:0]  op;
      logic [4:0]  rd, rs1, rs2, ma;
      logic [31:0] res;
      op = ins[1:0]; rd = ins[6:2]; rs1 = ins[11:7]; rs2 = ins[16:12]; ma = ins[21:17];
      exp_q.delete();
      if (GUARD && !op[1] && ma == 5'd31) begin
         exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end else if (op == 2'b00) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, ma, 1, 0));
         exp_q.push_back(mk(1, 1, 0, 1, rd, 0, 0, 0, 0, 0, 0));
         if (rd != 0) gr[rd] = gd[ma];
      end else if (op == 2'b01) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, rs1, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(1, 1, 0, 0, 0, rs1, 0, 1, ma, 0, 0));
         gd[ma] = gr[rs1];
      end else begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, rs1, rs2, 0, 0, 0, op[0]));
         exp_q.push_back(mk(1, 0, 0, 0, 0, rs1, rs2, 1, 5'd31, 0, op[0]));
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd31, 1, 0));
         exp_q.push_back(mk(1, 1, 0, 1, rd, 0, 0, 0, 0, 0, 0));
         res = op[0] ? gr[rs1] - gr[rs2] : gr[rs1] + gr[rs2];
         gd[31] = res;
         if (rd != 0) gr[rd] = res;
      end
   endtask

   task automatic check_state(input logic [31:0] ins);
      logic [4:0] da;
      da = ins[1] ? 5'd31 : ins[21:17];
      check($sformatf("rf[%0d]", ins[6:2]), rf[ins[6:2]], gr[ins[6:2]]);
      check($sformatf("dm[%0d]", da), dm[da], gd[da]);
   endtask

   // Entered and left at a negedge with the sequencer idle.
   task automatic do_instr(input logic [31:0] ins, input bit hold_valid);
      plan(ins);
      check("idle", {4'd0, obs}, {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         check($sformatf("ctl op%0d c%0d", ins[1:0], k + 1), {4'd0, obs}, {4'd0, exp_q[k]});
         instr       = $urandom;
         instr_valid = exp_q[k][27] ? 1'b0 : (hold_valid ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      instr_valid = 1'b0;
      check_state(ins);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         instr       = $urandom;
         instr_valid = 1'b0;
         @(negedge clk);
         check("gap", {4'd0, obs}, {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      end
   endtask

   task automatic reset_mid_add(input logic [31:0] ins);
      logic [31:0] res;
      check("idle", {4'd0, obs}, {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_add dm_read", {31'd0, dm_read}, 32'd1);
      // Only the scratch write in MEM_WR has landed; the rd write must never happen.
      res = ins[0] ? gr[ins[11:7]] - gr[ins[16:12]] : gr[ins[11:7]] + gr[ins[16:12]];
      gd[31] = res;
      rst = 1'b1;
      #1;
      check("rst_async", {4'd0, obs}, {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      @(posedge clk);
      @(negedge clk);
      check("rst_hold", {4'd0, obs}, {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      rst = 1'b0;
      check_state(ins);
   endtask

   initial begin
      logic [31:0] ins;
      logic [4:0]  ma;
      rst         = 1'b1;
      preload     = 1'b1;
      instr       = '0;
      instr_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         gr[i] = $urandom;
         gd[i] = $urandom;
      end
      gr[0] = 32'd0;
      gr[7] = 32'h1234;
      gr[1] = 32'd10;
      gr[2] = 32'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset", {4'd0, obs}, {4'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
      preload = 1'b0;
      rst     = 1'b0;

      do_instr(enc(2'b00, 5'd3, 5'd0, 5'd0, 5'd5), 1'b0);
      do_instr(enc(2'b01, 5'd0, 5'd7, 5'd0, 5'd9), 1'b0);
      check("dm9_sw", dm[9], 32'h1234);
      do_instr(enc(2'b11, 5'd4, 5'd1, 5'd2, 5'd0), 1'b0);
      check("r4_sub", rf[4], 32'd7);
      do_instr(enc(2'b00, 5'd6, 5'd0, 5'd0, 5'd12), 1'b1);
      do_instr(enc(2'b10, 5'd8, 5'd4, 5'd7, 5'd0), 1'b1);
      do_instr(enc(2'b01, 5'd0, 5'd4, 5'd0, 5'd31), 1'b0);
      do_instr(enc(2'b00, 5'd9, 5'd0, 5'd0, 5'd31), 1'b0);
      reset_mid_add(enc(2'b10, 5'd10, 5'd1, 5'd2, 5'd0));
      do_instr(enc(2'b00, 5'd11, 5'd0, 5'd0, 5'd9), 1'b0);

      for (int n = 0; n < 80; n++) begin
         ma  = (n % 8 == 3) ? 5'd31 : 5'($urandom);
         ins = enc(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), ma);
         do_instr(ins, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
      end

      for (int i = 0; i < 32; i++) begin
         check($sformatf("final rf[%0d]", i), rf[i], (i == 0) ? rf[0] & 32'd0 | gr[0] : gr[i]);
         check($sformatf("final dm[%0d]", i), dm[i], gd[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
